// File: rtl/lif_neuron_array_if.sv
// Step/result bundle between the current decoder, the LIF neuron array and the output mux.
// The master drives time steps and reads neuron results; the slave is the neuron array.
interface lif_neuron_array_if #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8,
  parameter int CNT_W     = 8
);
  logic                         in_valid;
  logic [N_NEURONS*WIDTH-1:0]   current;
  logic [WIDTH-1:0]             threshold;
  logic                         cnt_clear;
  logic [N_NEURONS*WIDTH-1:0]   state_out;
  logic [N_NEURONS-1:0]         spike;
  logic [N_NEURONS-1:0]         refractory;
  logic                         out_valid;
  logic [N_NEURONS*CNT_W-1:0]   spike_cnt;

  modport master (
    output in_valid, current, threshold, cnt_clear,
    input  state_out, spike, refractory, out_valid, spike_cnt
  );

  modport slave (
    input  in_valid, current, threshold, cnt_clear,
    output state_out, spike, refractory, out_valid, spike_cnt
  );
endinterface

// File: rtl/lif_neuron_array.sv
// Array of independent leaky integrate-and-fire neurons with shift leak, shared threshold and refractory period.
// Optional per-channel saturating spike counters are built when LIF_SPIKE_COUNT_EN is defined.
module lif_neuron_array #(
  parameter int N_NEURONS    = 4,
  parameter int WIDTH        = 8,
  parameter int LEAK_SHIFT   = 1,
  parameter int REFRAC_STEPS = 2,
  parameter int CNT_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  lif_neuron_array_if.slave    bus
);

  // A zero-length refractory still needs a one-bit counter that simply never loads.
  localparam int REFR_W = (REFRAC_STEPS < 1) ? 1 : $clog2(REFRAC_STEPS + 1);

  logic [N_NEURONS*WIDTH-1:0] state_vec;
  logic [N_NEURONS-1:0]       spike_vec;
  logic [N_NEURONS-1:0]       refr_vec;
  logic [N_NEURONS*CNT_W-1:0] cnt_vec;
  logic                       out_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
    end else begin
      out_valid_reg <= bus.in_valid;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_NEURONS; gi++) begin : g_ch
      logic [WIDTH-1:0]  state_reg, state_next;
      logic [REFR_W-1:0] refr_reg, refr_next;
      logic              spike_reg, spike_next;
      logic [WIDTH-1:0]  cur;
      logic [WIDTH-1:0]  leaked;
      logic [WIDTH:0]    sum_wide;
      logic [WIDTH-1:0]  sum_sat;

      assign cur = bus.current[gi*WIDTH +: WIDTH];

      always_comb begin
        leaked     = state_reg - (state_reg >> LEAK_SHIFT);
        sum_wide   = {1'b0, leaked} + {1'b0, cur};
        sum_sat    = sum_wide[WIDTH] ? {WIDTH{1'b1}} : sum_wide[WIDTH-1:0];
        state_next = state_reg;
        refr_next  = refr_reg;
        spike_next = 1'b0;
        if (bus.in_valid) begin
          if (refr_reg != '0) begin
            // Refractory steps clamp the membrane and ignore the input current.
            state_next = '0;
            refr_next  = refr_reg - REFR_W'(1);
          end else if (sum_sat >= bus.threshold) begin
            spike_next = 1'b1;
            state_next = '0;
            refr_next  = REFR_W'(REFRAC_STEPS);
          end else begin
            state_next = sum_sat;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= '0;
          refr_reg  <= '0;
          spike_reg <= 1'b0;
        end else begin
          state_reg <= state_next;
          refr_reg  <= refr_next;
          spike_reg <= spike_next;
        end
      end

      assign state_vec[gi*WIDTH +: WIDTH] = state_reg;
      assign spike_vec[gi]                = spike_reg;
      assign refr_vec[gi]                 = (refr_reg != '0);

`ifdef LIF_SPIKE_COUNT_EN
      logic [CNT_W-1:0] cnt_reg, cnt_next;

      // Counter moves on the same edge the spike appears, so both are visible together.
      always_comb begin
        cnt_next = cnt_reg;
        if (bus.cnt_clear) begin
          cnt_next = '0;
        end else if (spike_next && (cnt_reg != {CNT_W{1'b1}})) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign cnt_vec[gi*CNT_W +: CNT_W] = cnt_reg;
`else
      assign cnt_vec[gi*CNT_W +: CNT_W] = '0;
`endif
    end
  endgenerate

`ifndef LIF_SPIKE_COUNT_EN
  logic cnt_clear_unused;
  assign cnt_clear_unused = bus.cnt_clear;
`endif

  assign bus.state_out  = state_vec;
  assign bus.spike      = spike_vec;
  assign bus.refractory = refr_vec;
  assign bus.out_valid  = out_valid_reg;
  assign bus.spike_cnt  = cnt_vec;

endmodule

// File: tb/tb_lif_neuron_array.sv
// Scoreboard bench for lif_neuron_array (4 channels, 8-bit, leak shift 1, refractory 2).
// Expected step results are queued at drive time and compared when the DUT output appears.
module tb_lif_neuron_array;

  logic clk;
  logic rst;

  lif_neuron_array_if #(.N_NEURONS(4), .WIDTH(8), .CNT_W(8)) bus ();

  lif_neuron_array #(
    .N_NEURONS(4), .WIDTH(8), .LEAK_SHIFT(1), .REFRAC_STEPS(2), .CNT_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifdef LIF_SPIKE_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  typedef struct {
    logic        valid;
    logic [31:0] state;
    logic [3:0]  spike;
    logic [3:0]  refr;
    logic [31:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  int m_state[4];
  int m_refr[4];
  int m_cnt[4];
  bit m_spk[4];

  int trace_ch = 0;
  int st_trace[$];
  int sp_trace[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mk(input int c0, input int c1, input int c2, input int c3);
    return {c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
  endfunction

  // Applies inputs for the next rising edge and queues what the neurons should show after it.
  task automatic drive(input logic r, input logic v, input logic [31:0] cur,
                       input logic [7:0] thr, input logic clr);
    exp_t e;
    int   sum;
    rst           = r;
    bus.in_valid  = v;
    bus.current   = cur;
    bus.threshold = thr;
    bus.cnt_clear = clr;
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        m_state[i] = 0;
        m_refr[i]  = 0;
        m_spk[i]   = 1'b0;
        m_cnt[i]   = 0;
      end else begin
        m_spk[i] = 1'b0;
        if (v) begin
          if (m_refr[i] > 0) begin
            m_state[i] = 0;
            m_refr[i]  = m_refr[i] - 1;
          end else begin
            sum = m_state[i] - (m_state[i] / 2) + int'(cur[i*8 +: 8]);
            if (sum > 255) sum = 255;
            if (sum >= int'(thr)) begin
              m_spk[i]   = 1'b1;
              m_state[i] = 0;
              m_refr[i]  = 2;
            end else begin
              m_state[i] = sum;
            end
          end
        end
        if (clr) m_cnt[i] = 0;
        else if (m_spk[i] && m_cnt[i] < 255) m_cnt[i] = m_cnt[i] + 1;
      end
    end
    e.valid = !r && v;
    for (int i = 0; i < 4; i++) begin
      e.state[i*8 +: 8] = m_state[i][7:0];
      e.spike[i]        = m_spk[i];
      e.refr[i]         = (m_refr[i] != 0);
      e.cnt[i*8 +: 8]   = CNT_ON ? m_cnt[i][7:0] : 8'd0;
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    check("sb_depth", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    step_no++;
    check("out_valid",  64'(bus.out_valid),  64'(e.valid));
    check("state_out",  64'(bus.state_out),  64'(e.state));
    check("spike",      64'(bus.spike),      64'(e.spike));
    check("refractory", 64'(bus.refractory), 64'(e.refr));
    check("spike_cnt",  64'(bus.spike_cnt),  64'(e.cnt));
    if (bus.out_valid === 1'b1) begin
      st_trace.push_back(int'(bus.state_out[trace_ch*8 +: 8]));
      sp_trace.push_back(int'(bus.spike[trace_ch]));
    end
    $display("step %0d valid=%0b state=%08h spike=%04b refr=%04b cnt=%08h",
             step_no, bus.out_valid, bus.state_out, bus.spike, bus.refractory, bus.spike_cnt);
  endtask

  task automatic start_trace(input int ch);
    trace_ch = ch;
    st_trace.delete();
    sp_trace.delete();
  endtask

  task automatic check_trace(input string tag, input int want_st[$], input int want_sp[$]);
    check({tag, "_len"}, 64'(st_trace.size()), 64'(want_st.size()));
    for (int i = 0; i < want_st.size() && i < st_trace.size(); i++) begin
      check({tag, "_state"}, 64'(st_trace[i]), 64'(want_st[i]));
      check({tag, "_spike"}, 64'(sp_trace[i]), 64'(want_sp[i]));
    end
  endtask

  initial begin
    int want_st[$];
    int want_sp[$];
    logic [31:0] rc;

    // Reset held with full-scale current presented on every channel
    drive(1'b1, 1'b1, mk(255, 255, 255, 255), 8'd0, 1'b0); tick();
    drive(1'b1, 1'b1, mk(255, 255, 255, 255), 8'd0, 1'b0); tick();
    drive(1'b0, 1'b0, mk(0, 0, 0, 0), 8'd0, 1'b0); tick();

    // Sub-threshold integration on ch0
    start_trace(0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, mk(40, 0, 0, 0), 8'd200, 1'b0); tick();
    end
    want_st = '{40, 60, 70, 75, 78, 79, 80, 80};
    want_sp = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_trace("subthr", want_st, want_sp);

    // Fire and refractory on ch1
    drive(1'b1, 1'b0, mk(0, 0, 0, 0), 8'd0, 1'b0); tick();
    start_trace(1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, mk(0, 60, 0, 0), 8'd100, 1'b0); tick();
    end
    want_st = '{60, 90, 0, 0, 0, 60};
    want_sp = '{0, 0, 1, 0, 0, 0};
    check_trace("fire", want_st, want_sp);

    // Saturating sum on ch2
    drive(1'b1, 1'b0, mk(0, 0, 0, 0), 8'd0, 1'b0); tick();
    start_trace(2);
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, mk(0, 0, 200, 0), 8'd255, 1'b0); tick();
    end
    want_st = '{200, 0};
    want_sp = '{0, 1};
    check_trace("sat", want_st, want_sp);

    // Hold with in_valid low, then reset in the middle of refractory
    drive(1'b1, 1'b0, mk(0, 0, 0, 0), 8'd0, 1'b0); tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, mk(0, 60, 0, 0), 8'd200, 1'b0); tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, mk(0, 60, 0, 0), 8'd200, 1'b0); tick();
    end
    check("hold_state", 64'(bus.state_out[15:8]), 64'd90);
    drive(1'b0, 1'b1, mk(0, 60, 0, 0), 8'd100, 1'b0); tick();
    check("hold_fire_refr", 64'(bus.refractory[1]), 64'd1);
    drive(1'b1, 1'b1, mk(0, 60, 0, 0), 8'd100, 1'b0); tick();
    check("rst_refr", 64'(bus.refractory[1]), 64'd0);
    drive(1'b0, 1'b1, mk(0, 60, 0, 0), 8'd100, 1'b0); tick();
    check("post_rst_state", 64'(bus.state_out[15:8]), 64'd60);

    // Threshold zero: every non-refractory step fires on every channel
    drive(1'b1, 1'b0, mk(0, 0, 0, 0), 8'd0, 1'b0); tick();
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, mk(0, 0, 0, 1), 8'd0, 1'b0); tick();
    end
    check("cnt_ch3", 64'(bus.spike_cnt[31:24]), CNT_ON ? 64'd3 : 64'd0);
    drive(1'b0, 1'b1, mk(0, 0, 0, 1), 8'd0, 1'b1); tick();
    check("cnt_clear_ch3", 64'(bus.spike_cnt[31:24]), 64'd0);
    check("clear_step_spike", 64'(bus.spike[3]), 64'd1);

    // Random mix of steps, idles, clears and occasional resets
    for (int i = 0; i < 40; i++) begin
      rc = $urandom;
      drive($urandom_range(0, 29) == 0, $urandom_range(0, 3) != 0, rc,
            8'($urandom_range(0, 255)), $urandom_range(0, 9) == 0);
      tick();
    end

    drive(1'b0, 1'b0, mk(0, 0, 0, 0), 8'd0, 1'b0); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
